// File: rtl/cpu_clock_controller_if.sv
// Request/status bundle between the run-control logic (master) and the
// processor clock controller (slave).
interface cpu_clock_controller_if #(
    parameter int COUNT_WIDTH = 32
);
    logic                   run_request;
    logic                   halt_request;
    logic                   step_request;
    logic                   cpu_clock;
    logic                   cpu_clock_enable;
    logic                   running;
    logic [COUNT_WIDTH-1:0] cycle_count;

    // Debugger / run-control side: issues requests, observes the clock.
    modport master (
        output run_request,
        output halt_request,
        output step_request,
        input  cpu_clock,
        input  cpu_clock_enable,
        input  running,
        input  cycle_count
    );

    // Clock controller side.
    modport slave (
        input  run_request,
        input  halt_request,
        input  step_request,
        output cpu_clock,
        output cpu_clock_enable,
        output running,
        output cycle_count
    );
endinterface

// File: rtl/cpu_clock_controller.sv
// Processor clock generator: divides the board clock by DIVIDE under
// run / halt / single-step control, emits a one-cycle enable at the start
// of each processor clock period and counts the periods issued.
// DIVIDE must be even and >= 2.
module cpu_clock_controller #(
    parameter int DIVIDE      = 10,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    cpu_clock_controller_if.slave  bus
);
    localparam int DIV_W = (DIVIDE > 2) ? $clog2(DIVIDE) : 1;
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DIVIDE - 1);
    localparam logic [DIV_W-1:0] HALF = DIV_W'(DIVIDE / 2);

    localparam logic [1:0] ST_HALTED    = 2'd0;
    localparam logic [1:0] ST_RUNNING   = 2'd1;
    localparam logic [1:0] ST_STEP      = 2'd2;
    localparam logic [1:0] ST_STEP_HOLD = 2'd3;

    logic [1:0]             r_state;
    logic [DIV_W-1:0]       r_div;
    logic                   r_halt_pending;
    logic                   r_cpu_clock;
    logic                   r_enable;
    logic                   r_running;
    logic [COUNT_WIDTH-1:0] r_count;

    logic [1:0]             w_state_nxt;
    logic [DIV_W-1:0]       w_div_nxt;
    logic                   w_pend_nxt;
    logic                   w_last;
    logic                   w_active_nxt;

    assign w_last = (r_div == LAST);

    // Next-state / divider decision; a period in progress is always finished
    // before leaving an active state so cpu_clock never produces a runt pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_div_nxt   = r_div;
        w_pend_nxt  = r_halt_pending;
        case (r_state)
            ST_HALTED: begin
                w_div_nxt  = '0;
                w_pend_nxt = 1'b0;
                if (bus.run_request) begin
                    w_state_nxt = ST_RUNNING;
                end else if (bus.step_request) begin
                    w_state_nxt = ST_STEP;
                end
            end
            ST_RUNNING: begin
                if (w_last) begin
                    w_div_nxt = '0;
                    if (bus.halt_request || r_halt_pending) begin
                        w_state_nxt = ST_HALTED;
                        w_pend_nxt  = 1'b0;
                    end
                end else begin
                    w_div_nxt  = r_div + DIV_W'(1);
                    w_pend_nxt = r_halt_pending | bus.halt_request;
                end
            end
            ST_STEP: begin
                if (w_last) begin
                    w_div_nxt   = '0;
                    w_state_nxt = bus.step_request ? ST_STEP_HOLD : ST_HALTED;
                end else begin
                    w_div_nxt = r_div + DIV_W'(1);
                end
            end
            ST_STEP_HOLD: begin
                // Wait for the step request to drop so each assertion yields one period.
                w_div_nxt = '0;
                if (!bus.step_request) begin
                    w_state_nxt = ST_HALTED;
                end
            end
            default: begin
                w_state_nxt = ST_HALTED;
                w_div_nxt   = '0;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    assign w_active_nxt = (w_state_nxt == ST_RUNNING) || (w_state_nxt == ST_STEP);

    // State, divider and registered outputs; outputs are decoded from the next
    // state so they line up with the state they describe, with no extra delay.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_HALTED;
            r_div          <= '0;
            r_halt_pending <= 1'b0;
            r_cpu_clock    <= 1'b0;
            r_enable       <= 1'b0;
            r_running      <= 1'b0;
            r_count        <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_div          <= w_div_nxt;
            r_halt_pending <= w_pend_nxt;
            r_cpu_clock    <= w_active_nxt && (w_div_nxt < HALF);
            r_enable       <= w_active_nxt && (w_div_nxt == '0);
            r_running      <= (w_state_nxt == ST_RUNNING);
            r_count        <= r_count + {{(COUNT_WIDTH-1){1'b0}}, r_enable};
        end
    end

    assign bus.cpu_clock        = r_cpu_clock;
    assign bus.cpu_clock_enable = r_enable;
    assign bus.running          = r_running;
    assign bus.cycle_count      = r_count;
endmodule
